fetch_queue_unit: RTL and testbench

// - Parametrised instruction-fetch front end for the pipelined RAT core. Replaces the single fetch register and PC-delay stall scheme.
// - Owns the PC and issues sync-ROM reads. Buffers returned {instr, pc} in a DEPTH-entry queue and hands them to decode over a valid/ready handshake.
// - Handles branch redirects and interrupt vectoring, flushing all wrong-path work.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_queue_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_queue_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-path types and default widths, used by the fetch queue, decode and PC logic.
package fetch_pkg;

    localparam int unsigned       DEF_ADDR_W     = 10;
    localparam int unsigned       DEF_INSTR_W    = 18;
    localparam logic [9:0]        DEF_INT_VECTOR = 10'h3FF;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched entries; pointers carry an extra wrap bit so full/empty
// fall out of an MSB compare.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  entry_t                   wdata,
    input  logic                     pop,
    output entry_t                   rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [IDX_W:0] wr_q, rd_q;
    entry_t         mem_q [DEPTH];
    logic           do_push, do_pop;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[IDX_W] != rd_q[IDX_W]) && (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);
    assign count = wr_q - rd_q;
    assign rdata = mem_q[rd_q[IDX_W-1:0]];

    // Flush wins over any same-cycle push or pop.
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[IDX_W-1:0]] <= wdata;
                wr_q                   <= wr_q + {{IDX_W{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_q <= rd_q + {{IDX_W{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the PC, issues sync-ROM reads, queues {instr, pc}
// for decode and handles redirect / interrupt flushes.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W     = DEF_ADDR_W,
    parameter int unsigned       INSTR_W    = DEF_INSTR_W,
    parameter int unsigned       DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [ADDR_W-1:0] INT_VECTOR = DEF_INT_VECTOR
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               rom_en,
    input  logic [INSTR_W-1:0] rom_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               int_req,
    input  logic               int_en,
    output logic               int_ack,
    output logic [ADDR_W-1:0]  int_ret_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 2;
    localparam logic [CNT_W-1:0] DEPTH_C = DEPTH[CNT_W-1:0];

    // Entry type sized from this instance's widths.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] issue_pc_q, issue_pc_d;
    logic              pending_q, pending_d;
    logic              int_ack_q, int_ack_d;
    logic [ADDR_W-1:0] int_ret_pc_q, int_ret_pc_d;
    entry_t            last_q, last_d;

    logic              take_int, flush, issue, push, pop;
    logic              fifo_empty, fifo_full;
    logic [IDX_W:0]    fifo_count;
    logic [CNT_W-1:0]  occupancy;
    entry_t            fifo_wdata, fifo_rdata, head;

    assign take_int = int_req & int_en & ~redirect_valid;
    assign flush    = redirect_valid | take_int;

    // In-flight read counts against capacity so a returning word always has a slot.
    assign occupancy = {1'b0, fifo_count} + {{(CNT_W-1){1'b0}}, pending_q};
    assign issue     = rst_n & ~flush & (occupancy < DEPTH_C);
    assign push      = pending_q & ~flush;
    assign pop       = out_valid & out_ready;

    assign fifo_wdata.instr = rom_instr;
    assign fifo_wdata.pc    = issue_pc_q;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Outputs hold the last head seen once the queue drains.
    assign head = fifo_empty ? last_q : fifo_rdata;

    assign rom_addr   = pc_q;
    assign rom_en     = issue;
    assign out_valid  = ~fifo_empty & ~flush & ~fifo_full | ~fifo_empty & ~flush & fifo_full;
    assign out_instr  = head.instr;
    assign out_pc     = head.pc;
    assign int_ack    = int_ack_q;
    assign int_ret_pc = int_ret_pc_q;

    always_comb begin
        pc_d         = pc_q;
        issue_pc_d   = issue_pc_q;
        pending_d    = pending_q;
        int_ret_pc_d = int_ret_pc_q;
        int_ack_d    = take_int;
        last_d       = fifo_empty ? last_q : fifo_rdata;

        if (flush) begin
            pc_d      = redirect_valid ? redirect_addr : INT_VECTOR;
            pending_d = 1'b0;
        end else begin
            pending_d = issue;
            if (issue) begin
                pc_d       = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                issue_pc_d = pc_q;
            end
        end

        // Resume at the oldest instruction not yet handed to decode.
        if (take_int) begin
            if (!fifo_empty) begin
                int_ret_pc_d = fifo_rdata.pc;
            end else if (pending_q) begin
                int_ret_pc_d = issue_pc_q;
            end else begin
                int_ret_pc_d = pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            issue_pc_q   <= '0;
            pending_q    <= 1'b0;
            int_ack_q    <= 1'b0;
            int_ret_pc_q <= '0;
            last_q       <= '0;
        end else begin
            pc_q         <= pc_d;
            issue_pc_q   <= issue_pc_d;
            pending_q    <= pending_d;
            int_ack_q    <= int_ack_d;
            int_ret_pc_q <= int_ret_pc_d;
            last_q       <= last_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: expected fetch stream is queued by the stimulus
// and checked by an independent monitor on every decode handshake.
module tb_fetch_queue_unit;

    localparam int unsigned AW = 10;
    localparam int unsigned IW = 18;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, w_rst_n;
    logic [AW-1:0] rom_addr, redirect_addr, int_ret_pc, out_pc;
    logic          rom_en, redirect_valid, int_req, int_en, int_ack, out_valid, out_ready;
    logic [IW-1:0] rom_instr = '0;
    logic [IW-1:0] out_instr;

    logic [AW-1:0] w_rom_addr, w_int_ret_pc, w_out_pc;
    logic          w_rom_en, w_int_ack, w_out_valid;
    logic [IW-1:0] w_rom_instr = '0;
    logic [IW-1:0] w_out_instr;

    int            n_cmp = 0;
    int            n_err = 0;
    int            w_seen = 0;
    logic [AW-1:0] sb_q [$];

    fetch_queue_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_en         (rom_en),
        .rom_instr      (rom_instr),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .int_req        (int_req),
        .int_en         (int_en),
        .int_ack        (int_ack),
        .int_ret_pc     (int_ret_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    fetch_queue_unit #(
        .RESET_PC (10'h3FE)
    ) dut_wrap (
        .clk            (clk),
        .rst_n          (w_rst_n),
        .rom_addr       (w_rom_addr),
        .rom_en         (w_rom_en),
        .rom_instr      (w_rom_instr),
        .redirect_valid (1'b0),
        .redirect_addr  (10'h000),
        .int_req        (1'b0),
        .int_en         (1'b0),
        .int_ack        (w_int_ack),
        .int_ret_pc     (w_int_ret_pc),
        .out_valid      (w_out_valid),
        .out_ready      (1'b1),
        .out_instr      (w_out_instr),
        .out_pc         (w_out_pc)
    );

    function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] a);
        return {a[7:0] ^ 8'h5A, a};
    endfunction

    // Synchronous ROM models: data appears the cycle after the read.
    always @(posedge clk) if (rom_en) rom_instr <= instr_of(rom_addr);
    always @(posedge clk) if (w_rom_en) w_rom_instr <= instr_of(w_rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic expect_range(input logic [AW-1:0] first, input int n);
        logic [AW-1:0] a;
        a = first;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back(a);
            a = a + 10'd1;
        end
    endtask

    // Monitor: every handshake must match the next queued expectation.
    always @(negedge clk) begin
        logic [AW-1:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_transfer: got pc %0h, expected no transfer", out_pc);
            end else begin
                e = sb_q.pop_front();
                chk("out_pc", 32'(out_pc), 32'(e));
                chk("out_instr", 32'(out_instr), 32'(instr_of(e)));
            end
        end
    end

    always @(negedge clk) begin
        logic [AW-1:0] e;
        if (w_rst_n && w_out_valid) begin
            if (w_seen < 3) begin
                e = (w_seen == 0) ? 10'h3FE : (w_seen == 1) ? 10'h3FF : 10'h000;
                chk("wrap_pc", 32'(w_out_pc), 32'(e));
            end
            w_seen++;
        end
    end

    initial begin
        int ens;
        rst_n = 1'b0; w_rst_n = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_addr = '0; int_req = 1'b0; int_en = 1'b0;
        repeat (2) step();
        neg();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_rom_en", 32'(rom_en), 0);
        chk("rst_int_ack", 32'(int_ack), 0);
        chk("rst_int_ret_pc", 32'(int_ret_pc), 0);
        chk("rst_out_pc", 32'(out_pc), 0);
        chk("rst_out_instr", 32'(out_instr), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);

        // Stall from reset: four issues fill the queue, head held at 0.
        step();
        rst_n = 1'b1; w_rst_n = 1'b1;
        ens = 0;
        for (int c = 0; c < 10; c++) begin
            neg();
            if (rom_en) ens++;
            chk("stall_valid", 32'(out_valid), 32'(c >= 2));
            if (c >= 2) chk("stall_held_pc", 32'(out_pc), 0);
            chk("stall_int_ack", 32'(int_ack), 0);
            step();
        end
        chk("stall_issue_count", 32'(ens), 4);

        // Release: 0..7 with no bubble.
        expect_range(10'h000, 8);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            neg();
            chk("release_no_gap", 32'(out_valid), 1);
            step();
        end
        out_ready = 1'b0;
        repeat (6) step();
        chk("drain_release", 32'(sb_q.size()), 0);

        // Branch redirect while 8..11 are queued.
        expect_range(10'h120, 6);
        redirect_valid = 1'b1; redirect_addr = 10'h120; out_ready = 1'b1;
        neg();
        chk("redir_no_transfer", 32'(out_valid), 0);
        chk("redir_no_issue", 32'(rom_en), 0);
        step();
        redirect_valid = 1'b0;
        neg();
        chk("redir_cleared", 32'(out_valid), 0);
        chk("redir_issue_en", 32'(rom_en), 1);
        chk("redir_issue_addr", 32'(rom_addr), 'h120);
        step();
        neg();
        chk("redir_wait", 32'(out_valid), 0);
        step();
        neg();
        chk("redir_first_valid", 32'(out_valid), 1);
        chk("redir_first_pc", 32'(out_pc), 'h120);
        step();
        repeat (5) step();
        out_ready = 1'b0;
        repeat (6) step();
        chk("drain_redirect", 32'(sb_q.size()), 0);

        // Interrupt taken with head pc 0x040.
        redirect_valid = 1'b1; redirect_addr = 10'h040;
        step();
        redirect_valid = 1'b0;
        repeat (5) step();
        neg();
        chk("int_head_valid", 32'(out_valid), 1);
        chk("int_head_pc", 32'(out_pc), 'h040);
        step();
        expect_range(10'h3FF, 3);
        int_req = 1'b1; int_en = 1'b1; out_ready = 1'b1;
        neg();
        chk("int_no_transfer", 32'(out_valid), 0);
        chk("int_ack_early", 32'(int_ack), 0);
        step();
        int_req = 1'b0;
        neg();
        chk("int_ack_pulse", 32'(int_ack), 1);
        chk("int_ret_pc_head", 32'(int_ret_pc), 'h040);
        step();
        neg();
        chk("int_ack_single", 32'(int_ack), 0);
        step();
        neg();
        chk("int_vector_pc", 32'(out_pc), 'h3FF);
        repeat (3) step();
        out_ready = 1'b0;
        repeat (6) step();
        chk("drain_int", 32'(sb_q.size()), 0);

        // Interrupt masked: stream continues untouched.
        expect_range(10'h002, 4);
        int_req = 1'b1; int_en = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            neg();
            chk("masked_int_ack", 32'(int_ack), 0);
            chk("masked_valid", 32'(out_valid), 1);
            step();
        end
        out_ready = 1'b0; int_req = 1'b0;
        neg();
        chk("masked_int_ack_late", 32'(int_ack), 0);
        repeat (6) step();
        chk("drain_masked", 32'(sb_q.size()), 0);

        // Redirect and interrupt together: redirect first, interrupt next cycle.
        expect_range(10'h3FF, 2);
        redirect_valid = 1'b1; redirect_addr = 10'h200; int_req = 1'b1; int_en = 1'b1;
        out_ready = 1'b1;
        neg();
        chk("both_no_transfer", 32'(out_valid), 0);
        step();
        redirect_valid = 1'b0;
        neg();
        chk("both_ack_deferred", 32'(int_ack), 0);
        chk("both_no_issue", 32'(rom_en), 0);
        step();
        int_req = 1'b0;
        neg();
        chk("both_int_ack", 32'(int_ack), 1);
        chk("both_int_ret_pc", 32'(int_ret_pc), 'h200);
        step();
        neg();
        chk("both_ack_single", 32'(int_ack), 0);
        step();
        neg();
        chk("both_vector_pc", 32'(out_pc), 'h3FF);
        repeat (2) step();
        out_ready = 1'b0;
        repeat (6) step();
        chk("drain_both", 32'(sb_q.size()), 0);

        // Reset mid-stream: output drops at once, fetch restarts at 0.
        expect_range(10'h001, 2);
        out_ready = 1'b1;
        repeat (2) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_rom_en", 32'(rom_en), 0);
        chk("async_rst_pc", 32'(rom_addr), 0);
        chk("async_rst_out_pc", 32'(out_pc), 0);
        step();
        step();
        rst_n = 1'b1;
        expect_range(10'h000, 6);
        for (int c = 0; c < 8; c++) begin
            neg();
            chk("restart_valid", 32'(out_valid), 32'(c >= 2));
            step();
        end
        out_ready = 1'b0;
        repeat (6) step();
        chk("drain_restart", 32'(sb_q.size()), 0);
        chk("wrap_seen", 32'(w_seen >= 3), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
